// File: rtl/pattern_detect_ctrl.sv
// Programmable serial pattern detector with a config handshake and match counting.
// The config path loads pattern/len/target. Each run is armed, then scans the x
// stream with overlap, counts matches, and stops on the target count or on abort.
module pattern_detect_ctrl #(
  parameter int unsigned MAX_LEN = 8,
  parameter int unsigned LEN_W   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [CNT_W-1:0]   cfg_target,
  output logic               cfg_err,
  input  logic               start,
  input  logic               abort,
  input  logic               x,
  input  logic               x_valid,
  output logic               z,
  output logic [CNT_W-1:0]   match_count,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOADED = 2'd1,
    ST_ARMED  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t             r_state;
  logic [MAX_LEN-1:0] r_pattern;
  logic [LEN_W-1:0]   r_len;
  logic [CNT_W-1:0]   r_target;
  // Only MAX_LEN-1 past bits are kept; the incoming bit completes the window.
  logic [MAX_LEN-2:0] r_hist;
  logic [LEN_W-1:0]   r_fill;
  logic [CNT_W-1:0]   r_count;
  logic               r_z;
  logic               r_cfg_err;
  logic               r_cfg_ready;
  logic               r_busy;
  logic               r_done;

  logic               w_cfg_legal;
  logic [MAX_LEN-1:0] w_hist_next;
  logic [MAX_LEN-1:0] w_mask;
  logic               w_fill_ok;
  logic               w_hit;
  logic [CNT_W-1:0]   w_count_inc;
  logic [LEN_W-1:0]   w_fill_next;
  logic               w_target_hit;

  // Match detection on the window that includes the current bit.
  always_comb begin
    w_cfg_legal = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));
    w_hist_next = {r_hist, x};
    w_mask      = '0;
    for (int unsigned i = 0; i < MAX_LEN; i++) begin
      w_mask[i] = (i < 32'(r_len));
    end
    w_fill_ok    = (({1'b0, r_fill} + (LEN_W + 1)'(1)) >= {1'b0, r_len});
    w_hit        = w_fill_ok && ((w_hist_next & w_mask) == (r_pattern & w_mask));
    w_count_inc  = (r_count == '1) ? r_count : r_count + CNT_W'(1);
    w_fill_next  = (r_fill < r_len) ? r_fill + LEN_W'(1) : r_fill;
    w_target_hit = (r_target != '0) && (w_count_inc == r_target);
  end

  // Control FSM with registered status outputs and the scan datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_pattern   <= '0;
      r_len       <= '0;
      r_target    <= '0;
      r_hist      <= '0;
      r_fill      <= '0;
      r_count     <= '0;
      r_z         <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_cfg_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_z       <= 1'b0;
      r_cfg_err <= 1'b0;
      case (r_state)
        ST_IDLE, ST_LOADED: begin
          if (cfg_valid) begin
            // A config offer always takes precedence over start.
            if (w_cfg_legal) begin
              r_pattern <= cfg_pattern;
              r_len     <= cfg_len;
              r_target  <= cfg_target;
              r_state   <= ST_LOADED;
            end else begin
              r_cfg_err <= 1'b1;
            end
          end else if (start && (r_state == ST_LOADED)) begin
            r_state     <= ST_ARMED;
            r_hist      <= '0;
            r_fill      <= '0;
            r_count     <= '0;
            r_cfg_ready <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (abort) begin
            r_state     <= ST_LOADED;
            r_cfg_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else if (x_valid) begin
            r_hist <= w_hist_next[MAX_LEN-2:0];
            r_fill <= w_fill_next;
            if (w_hit) begin
              r_z     <= 1'b1;
              r_count <= w_count_inc;
              if (w_target_hit) begin
                r_state <= ST_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end
          end
        end
        ST_DONE: begin
          if (abort) begin
            r_state     <= ST_LOADED;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b1;
          end else if (start) begin
            r_state <= ST_ARMED;
            r_hist  <= '0;
            r_fill  <= '0;
            r_count <= '0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready   = r_cfg_ready;
  assign cfg_err     = r_cfg_err;
  assign z           = r_z;
  assign match_count = r_count;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_pattern_detect_ctrl.sv
// Bench for pattern_detect_ctrl: constant vector table, directed corner sequences,
// and random traffic against a bit-queue reference model.
module tb_pattern_detect_ctrl;
  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int CNT_W   = 8;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_valid;
  logic               cfg_ready;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic [CNT_W-1:0]   cfg_target;
  logic               cfg_err;
  logic               start;
  logic               abort;
  logic               x;
  logic               x_valid;
  logic               z;
  logic [CNT_W-1:0]   match_count;
  logic               busy;
  logic               done;

  pattern_detect_ctrl #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_pattern(cfg_pattern),
    .cfg_len    (cfg_len),
    .cfg_target (cfg_target),
    .cfg_err    (cfg_err),
    .start      (start),
    .abort      (abort),
    .x          (x),
    .x_valid    (x_valid),
    .z          (z),
    .match_count(match_count),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: config registers, run flags and the list of bits seen this run.
  bit       m_have, m_run, m_fin, m_z, m_err;
  int       m_pat, m_len, m_tgt, m_count;
  bit       m_bits[$];

  function automatic bit tail_matches();
    int v;
    int n;
    v = 0;
    n = m_bits.size();
    if (n < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) v = (v << 1) | int'(m_bits[n - m_len + i]);
    return v == (m_pat & ((1 << m_len) - 1));
  endfunction

  task automatic model_reset();
    m_have = 0; m_run = 0; m_fin = 0; m_z = 0; m_err = 0;
    m_pat = 0; m_len = 0; m_tgt = 0; m_count = 0;
    m_bits.delete();
  endtask

  task automatic model_clk();
    bit legal;
    legal = (int'(cfg_len) >= 1) && (int'(cfg_len) <= MAX_LEN);
    m_z   = 0;
    m_err = 0;
    if (m_run) begin
      if (abort) begin
        m_run = 0;
      end else if (x_valid) begin
        m_bits.push_back(x);
        if (m_bits.size() > MAX_LEN) void'(m_bits.pop_front());
        if (tail_matches()) begin
          m_z = 1;
          if (m_count < 255) m_count++;
          if (m_tgt != 0 && m_count == m_tgt) begin
            m_run = 0;
            m_fin = 1;
          end
        end
      end
    end else if (m_fin) begin
      if (abort) begin
        m_fin = 0;
      end else if (start) begin
        m_fin = 0; m_run = 1; m_count = 0; m_bits.delete();
      end
    end else begin
      if (cfg_valid) begin
        if (legal) begin
          m_have = 1; m_pat = int'(cfg_pattern); m_len = int'(cfg_len); m_tgt = int'(cfg_target);
        end else begin
          m_err = 1;
        end
      end else if (start && m_have) begin
        m_run = 1; m_count = 0; m_bits.delete();
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".ready"}, 32'(cfg_ready), 32'(!m_run && !m_fin));
    chk({tag, ".err"},   32'(cfg_err),   32'(m_err));
    chk({tag, ".z"},     32'(z),         32'(m_z));
    chk({tag, ".count"}, 32'(match_count), 32'(m_count));
    chk({tag, ".busy"},  32'(busy),      32'(m_run));
    chk({tag, ".done"},  32'(done),      32'(m_fin));
  endtask

  task automatic idle_inputs();
    cfg_valid = 0; cfg_pattern = '0; cfg_len = '0; cfg_target = '0;
    start = 0; abort = 0; x = 0; x_valid = 0;
  endtask

  task automatic cyc(input string tag);
    model_clk();
    @(posedge clk);
    #1;
    check_model(tag);
  endtask

  // Asserted away from the clock edge; outputs must clear before the next edge.
  task automatic do_reset();
    reset = 1;
    model_reset();
    #2;
    check_model("rst");
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  task automatic load(input int pat, input int len, input int tgt, input string tag);
    cfg_valid = 1; cfg_pattern = 8'(pat); cfg_len = 4'(len); cfg_target = 8'(tgt);
    cyc(tag);
    idle_inputs();
  endtask

  task automatic pulse_start(input string tag);
    start = 1;
    cyc(tag);
    start = 0;
  endtask

  task automatic send_bit(input bit b, input string tag);
    x = b; x_valid = 1;
    cyc(tag);
    x = 0; x_valid = 0;
  endtask

  typedef struct {
    logic       cv;
    logic [7:0] pat;
    logic [3:0] len;
    logic [7:0] tgt;
    logic       st, ab, xx, xv;
    logic       e_ready, e_err, e_z;
    logic [7:0] e_cnt;
    logic       e_busy, e_done;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic cv, input logic [7:0] pat, input logic [3:0] len,
                              input logic [7:0] tgt, input logic st, input logic ab,
                              input logic xx, input logic xv, input logic e_ready,
                              input logic e_err, input logic e_z, input logic [7:0] e_cnt,
                              input logic e_busy, input logic e_done);
    vec_t v;
    v.cv = cv; v.pat = pat; v.len = len; v.tgt = tgt; v.st = st; v.ab = ab; v.xx = xx; v.xv = xv;
    v.e_ready = e_ready; v.e_err = e_err; v.e_z = e_z; v.e_cnt = e_cnt;
    v.e_busy = e_busy; v.e_done = e_done;
    return v;
  endfunction

  initial begin
    int zc;
    idle_inputs();

    // Vector table: illegal lengths in IDLE, 101010 overlap run, abort, reload.
    tbl.push_back(mk(1, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0,  1, 1, 0, 8'd0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0,  1, 0, 0, 8'd0, 0, 0));
    tbl.push_back(mk(1, 8'hFF, 4'd9, 8'd0, 0, 0, 0, 0,  1, 1, 0, 8'd0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0,  1, 0, 0, 8'd0, 0, 0));
    tbl.push_back(mk(1, 8'h2A, 4'd6, 8'd0, 0, 0, 0, 0,  1, 0, 0, 8'd0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0,  0, 0, 0, 8'd0, 1, 0));
    for (int k = 1; k <= 10; k++) begin
      logic       ez;
      logic [7:0] ec;
      ez = (k == 6) || (k == 8) || (k == 10);
      ec = (k < 6) ? 8'd0 : (k < 8) ? 8'd1 : (k < 10) ? 8'd2 : 8'd3;
      tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, logic'(k % 2), 1,  0, 0, ez, ec, 1, 0));
    end
    tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 0,  0, 0, 0, 8'd3, 1, 0));
    tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 1, 0, 0,  1, 0, 0, 8'd3, 0, 0));
    tbl.push_back(mk(1, 8'h00, 4'd0, 8'd0, 0, 0, 0, 0,  1, 1, 0, 8'd3, 0, 0));
    tbl.push_back(mk(1, 8'h03, 4'd2, 8'd0, 1, 0, 0, 0,  1, 0, 0, 8'd3, 0, 0));
    tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 1, 0, 0, 0,  0, 0, 0, 8'd0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1,  0, 0, 0, 8'd0, 1, 0));
    tbl.push_back(mk(0, 8'h00, 4'd0, 8'd0, 0, 0, 1, 1,  0, 0, 1, 8'd1, 1, 0));

    do_reset();
    for (int r = 0; r < tbl.size(); r++) begin
      cfg_valid = tbl[r].cv; cfg_pattern = tbl[r].pat; cfg_len = tbl[r].len;
      cfg_target = tbl[r].tgt; start = tbl[r].st; abort = tbl[r].ab;
      x = tbl[r].xx; x_valid = tbl[r].xv;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d.ready", r), 32'(cfg_ready), 32'(tbl[r].e_ready));
      chk($sformatf("tbl%0d.err", r),   32'(cfg_err),   32'(tbl[r].e_err));
      chk($sformatf("tbl%0d.z", r),     32'(z),         32'(tbl[r].e_z));
      chk($sformatf("tbl%0d.count", r), 32'(match_count), 32'(tbl[r].e_cnt));
      chk($sformatf("tbl%0d.busy", r),  32'(busy),      32'(tbl[r].e_busy));
      chk($sformatf("tbl%0d.done", r),  32'(done),      32'(tbl[r].e_done));
    end
    idle_inputs();

    // 0110 with x_valid gaps: matches end on bits 4 and 7.
    do_reset();
    load(6, 4, 0, "t2_load");
    pulse_start("t2_start");
    zc = 0;
    for (int k = 1; k <= 7; k++) begin
      bit b;
      b = (k == 2) || (k == 3) || (k == 5) || (k == 6);
      send_bit(b, $sformatf("t2_b%0d", k));
      chk($sformatf("t2_z_b%0d", k), 32'(z), 32'((k == 4) || (k == 7)));
      zc += int'(z);
      if (k == 1 || k == 4 || k == 6) cyc("t2_gap");
      if (k == 4) cyc("t2_gap2");
    end
    chk("t2_zcount", 32'(zc), 32'd2);
    chk("t2_count", 32'(match_count), 32'd2);

    // Target 2, pattern 11: DONE after bit 3, bit 4 ignored.
    do_reset();
    load(3, 2, 2, "t3_load");
    pulse_start("t3_start");
    for (int k = 1; k <= 4; k++) begin
      send_bit(1'b1, $sformatf("t3_b%0d", k));
      chk($sformatf("t3_z_b%0d", k), 32'(z), 32'((k == 2) || (k == 3)));
    end
    chk("t3_done", 32'(done), 32'd1);
    chk("t3_busy", 32'(busy), 32'd0);
    chk("t3_count", 32'(match_count), 32'd2);
    start = 1; abort = 1;
    cyc("t3_start_abort");
    idle_inputs();
    chk("t3_abort_wins", 32'(cfg_ready), 32'd1);

    // Abort on the completing bit: no z, count kept, restart clears it.
    do_reset();
    load(5, 3, 0, "t5_load");
    pulse_start("t5_start");
    send_bit(1'b1, "t5_b1");
    send_bit(1'b0, "t5_b2");
    send_bit(1'b1, "t5_b3");
    send_bit(1'b0, "t5_b4");
    x = 1; x_valid = 1; abort = 1;
    cyc("t5_abort");
    idle_inputs();
    chk("t5_abort_z", 32'(z), 32'd0);
    chk("t5_abort_count", 32'(match_count), 32'd1);
    chk("t5_abort_ready", 32'(cfg_ready), 32'd1);
    pulse_start("t5_restart");
    chk("t5_restart_count", 32'(match_count), 32'd0);
    chk("t5_restart_busy", 32'(busy), 32'd1);

    // Reset in the middle of a partial match loses the config.
    do_reset();
    load(6, 4, 0, "t6_load");
    pulse_start("t6_start");
    send_bit(1'b0, "t6_b1");
    send_bit(1'b1, "t6_b2");
    send_bit(1'b1, "t6_b3");
    do_reset();
    chk("t6_ready", 32'(cfg_ready), 32'd1);
    chk("t6_busy", 32'(busy), 32'd0);
    pulse_start("t6_start_ignored");
    chk("t6_start_ignored", 32'(busy), 32'd0);
    x = 0; x_valid = 1;
    cyc("t6_bit_ignored");
    idle_inputs();
    chk("t6_no_z", 32'(z), 32'd0);

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      int r;
      cfg_valid   = ($urandom_range(0, 7) == 0);
      cfg_pattern = 8'($urandom);
      r           = int'($urandom_range(0, 15));
      cfg_len     = (r < 10) ? 4'($urandom_range(1, 3)) : 4'($urandom_range(0, 9));
      cfg_target  = 8'($urandom_range(0, 3));
      start       = ($urandom_range(0, 9) == 0);
      abort       = ($urandom_range(0, 39) == 0);
      x           = 1'($urandom);
      x_valid     = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc("rnd");
    end
    idle_inputs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
